// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX pipeline registers with stall/flush control and event counters
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [31:0]       PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       PCPlus4F,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       ImmExtD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [CTRL_W-1:0] CtrlD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic [31:0]       PCE,
  output logic [31:0]       PCPlus4E,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       ImmExtE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE,
  output logic [15:0]       StallCnt,
  output logic [15:0]       FlushCnt
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // fetch PC advances only while StallF (an enable) is high
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) PCF <= RESET_PC;
    else if (StallF) PCF <= PCNextF;

  // IF/ID: flush beats load/hold, so a redirect always kills the fetched slot
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || FlushD) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end

  // ID/EX: no hold path, it either takes decode values or becomes a bubble
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || FlushE) begin
      PCE      <= '0;
      PCPlus4E <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      CtrlE    <= '0;
      ValidE   <= 1'b0;
    end else begin
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
      CtrlE    <= CtrlD;
      ValidE   <= ValidD;
    end

  // saturating counts of fetch-stall edges and execute-flush edges
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (!StallF && StallCnt != 16'hFFFF) StallCnt <= StallCnt + 16'd1;
      if (FlushE && FlushCnt != 16'hFFFF) FlushCnt <= FlushCnt + 16'd1;
    end
endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed vector table, random run against a stage model, saturation and async reset checks
module tb_pipe_front_regs;
  localparam int CW = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF, PCPlus4F, RD1D, RD2D, ImmExtD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [CW-1:0] CtrlD;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
  logic ValidD, ValidE;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [CW-1:0] CtrlE;
  logic [15:0] StallCnt, FlushCnt;

  always #5 clk = ~clk;

  pipe_front_regs #(.RESET_PC(32'h0), .CTRL_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .CtrlD(CtrlD), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .CtrlE(CtrlE), .ValidE(ValidE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] instr, pc, pc4; logic v;} fdT;
  typedef struct {logic [31:0] pc, pc4, rd1, rd2, imm; logic [4:0] rs1, rs2, rd; logic [CW-1:0] ctrl; logic v;} exT;
  localparam fdT BUBBLE_D = '{32'h13, 32'h0, 32'h0, 1'b0};
  localparam exT BUBBLE_E = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 5'h0, 5'h0, '0, 1'b0};
  logic [31:0] mPC;
  fdT mD;
  exT mE;
  int mSc, mFc;

  function automatic void modelReset();
    mPC = 32'h0; mD = BUBBLE_D; mE = BUBBLE_E; mSc = 0; mFc = 0;
  endfunction

  function automatic void modelEdge();
    fdT nD;
    exT nE;
    nE = FlushE ? BUBBLE_E : '{mD.pc, mD.pc4, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD, CtrlD, mD.v};
    nD = FlushD ? BUBBLE_D : StallD ? '{InstrF, mPC, PCPlus4F, 1'b1} : mD;
    if (StallF) mPC = PCNextF;
    mD = nD;
    mE = nE;
    if (!StallF) mSc = (mSc < 65535) ? mSc + 1 : 65535;
    if (FlushE) mFc = (mFc < 65535) ? mFc + 1 : 65535;
  endfunction

  task automatic checkAll();
    chk("PCF", PCF, mPC);
    chk("InstrD", InstrD, mD.instr);
    chk("PCD", PCD, mD.pc);
    chk("PCPlus4D", PCPlus4D, mD.pc4);
    chk("ValidD", ValidD, mD.v);
    chk("PCE", PCE, mE.pc);
    chk("PCPlus4E", PCPlus4E, mE.pc4);
    chk("RD1E", RD1E, mE.rd1);
    chk("RD2E", RD2E, mE.rd2);
    chk("ImmExtE", ImmExtE, mE.imm);
    chk("Rs1E", Rs1E, mE.rs1);
    chk("Rs2E", Rs2E, mE.rs2);
    chk("RdE", RdE, mE.rd);
    chk("CtrlE", CtrlE, mE.ctrl);
    chk("ValidE", ValidE, mE.v);
    chk("StallCnt", StallCnt, mSc[15:0]);
    chk("FlushCnt", FlushCnt, mFc[15:0]);
  endtask

  typedef struct {
    logic sf, sd, fd, fe;
    logic [31:0] instr, pcNext, ePCF, eInstrD;
    logic eVD, eVE;
    logic [15:0] eCtrl, eSc, eFc;
  } vecT;
  vecT vec[8];

  task automatic checkResetState(input string tag);
    chk({tag, "_PCF"}, PCF, 32'h0);
    chk({tag, "_InstrD"}, InstrD, 32'h13);
    chk({tag, "_ValidD"}, ValidD, 1'b0);
    chk({tag, "_ValidE"}, ValidE, 1'b0);
    chk({tag, "_CtrlE"}, CtrlE, '0);
    chk({tag, "_StallCnt"}, StallCnt, 16'h0);
    chk({tag, "_FlushCnt"}, FlushCnt, 16'h0);
  endtask

  initial begin
    vec[0] = '{1, 1, 0, 0, 32'h00500093, 32'd4,  32'd4,  32'h00500093, 1, 0, 16'hA5A5, 16'd0, 16'd0};
    vec[1] = '{1, 1, 0, 0, 32'h00500093, 32'd8,  32'd8,  32'h00500093, 1, 1, 16'hA5A5, 16'd0, 16'd0};
    vec[2] = '{1, 1, 0, 0, 32'h0002A303, 32'd12, 32'd12, 32'h0002A303, 1, 1, 16'hA5A5, 16'd0, 16'd0};
    vec[3] = '{0, 0, 0, 1, 32'hDEADBEEF, 32'd16, 32'd12, 32'h0002A303, 1, 0, 16'h0000, 16'd1, 16'd1};
    vec[4] = '{1, 1, 0, 0, 32'h00100113, 32'd16, 32'd16, 32'h00100113, 1, 1, 16'hA5A5, 16'd1, 16'd1};
    vec[5] = '{1, 1, 1, 1, 32'h11111111, 32'd20, 32'd20, 32'h00000013, 0, 0, 16'h0000, 16'd1, 16'd2};
    vec[6] = '{1, 1, 0, 0, 32'h22222222, 32'd24, 32'd24, 32'h22222222, 1, 0, 16'hA5A5, 16'd1, 16'd2};
    vec[7] = '{0, 0, 1, 0, 32'h33333333, 32'd28, 32'd24, 32'h00000013, 0, 1, 16'hA5A5, 16'd2, 16'd2};
    {StallF, StallD, FlushD, FlushE} = 4'b1100;
    PCNextF = 32'd4; InstrF = 32'h0; PCPlus4F = 32'd4;
    RD1D = 32'h1; RD2D = 32'h2; ImmExtD = 32'h3; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; CtrlD = 16'hA5A5;
    repeat (3) @(posedge clk);
    #1 checkResetState("rst_hold");
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {StallF, StallD, FlushD, FlushE} = {vec[i].sf, vec[i].sd, vec[i].fd, vec[i].fe};
      InstrF = vec[i].instr; PCNextF = vec[i].pcNext; PCPlus4F = vec[i].pcNext;
      @(posedge clk); #1;
      chk($sformatf("v%0d_PCF", i), PCF, vec[i].ePCF);
      chk($sformatf("v%0d_InstrD", i), InstrD, vec[i].eInstrD);
      chk($sformatf("v%0d_ValidD", i), ValidD, vec[i].eVD);
      chk($sformatf("v%0d_ValidE", i), ValidE, vec[i].eVE);
      chk($sformatf("v%0d_CtrlE", i), CtrlE, vec[i].eCtrl);
      chk($sformatf("v%0d_StallCnt", i), StallCnt, vec[i].eSc);
      chk($sformatf("v%0d_FlushCnt", i), FlushCnt, vec[i].eFc);
    end

    reset_n = 1'b0; #1;
    checkResetState("rst_async0");
    @(negedge clk) reset_n = 1'b1;
    modelReset();
    for (int i = 0; i < 500; i++) begin
      StallF = $urandom_range(0, 3) != 0;
      StallD = $urandom_range(0, 3) != 0;
      FlushD = $urandom_range(0, 5) == 0;
      FlushE = $urandom_range(0, 4) == 0;
      PCNextF = ($urandom_range(0, 7) == 0) ? $urandom : mPC + 32'd4;
      PCPlus4F = mPC + 32'd4;
      InstrF = $urandom; RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
      Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom); CtrlD = 16'($urandom);
      modelEdge();
      @(posedge clk); #1;
      checkAll();
    end

    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    {StallF, StallD, FlushD, FlushE} = 4'b0000;
    repeat (65534) @(posedge clk);
    #1 chk("sat_FFFE", StallCnt, 16'hFFFE);
    @(posedge clk); #1 chk("sat_FFFF", StallCnt, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1 chk("sat_hold", StallCnt, 16'hFFFF);
    chk("sat_PCF", PCF, 32'h0);
    chk("sat_FlushCnt", FlushCnt, 16'h0);

    {StallF, StallD, FlushD, FlushE} = 4'b1100;
    PCNextF = 32'h100; InstrF = 32'h00A00513;
    @(posedge clk); #1 chk("pre_PCF", PCF, 32'h100);
    {StallF, StallD, FlushD, FlushE} = 4'b0001;
    repeat (2) @(posedge clk);
    #1 chk("pre_FlushCnt", FlushCnt, 16'd2);
    @(negedge clk); #2 reset_n = 1'b0;
    #1 checkResetState("rst_async");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
